// File: rtl/imm_gen_buffer_pkg.sv
// rtl/imm_gen_buffer_pkg.sv - shared LEGv8 decode constants: opcode casez patterns and immediate kinds
package imm_gen_buffer_pkg;

    localparam int INSTR_LEN    = 32;
    localparam int WORD_DEFAULT = 64;

    // 11-bit opcode patterns on instr[31:21]; '?' bits are don't-care in casez
    localparam logic [10:0] OP_LSL   = 11'b11010011011;
    localparam logic [10:0] OP_LSR   = 11'b11010011010;
    localparam logic [10:0] OP_ADDI  = 11'b1001000100?;
    localparam logic [10:0] OP_ANDI  = 11'b1001001000?;
    localparam logic [10:0] OP_ORRI  = 11'b1011001000?;
    localparam logic [10:0] OP_EORI  = 11'b1101001000?;
    localparam logic [10:0] OP_SUBI  = 11'b1101000100?;
    localparam logic [10:0] OP_CMPI  = 11'b1111000100?;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [10:0] OP_LDA   = 11'b11111000110;
    localparam logic [10:0] OP_CBZ   = 11'b10110100???;
    localparam logic [10:0] OP_CBNZ  = 11'b10110101???;
    localparam logic [10:0] OP_BCOND = 11'b01010100???;
    localparam logic [10:0] OP_B     = 11'b000101?????;
    localparam logic [10:0] OP_BL    = 11'b100101?????;
    localparam logic [10:0] OP_MOVK  = 11'b111100101??;
    localparam logic [10:0] OP_MOVZ  = 11'b110100101??;

    typedef enum logic [2:0] {
        IMM_KIND_NONE   = 3'd0,
        IMM_KIND_SHAMT  = 3'd1,
        IMM_KIND_ALU12  = 3'd2,
        IMM_KIND_DT9    = 3'd3,
        IMM_KIND_COND19 = 3'd4,
        IMM_KIND_BR26   = 3'd5,
        IMM_KIND_WIDE16 = 3'd6
    } imm_kind_e;

endpackage

// File: rtl/imm_extract.sv
// rtl/imm_extract.sv - combinational LEGv8 immediate classify/extend; LEGV8_BR_SCALE_EN selects byte branch offsets
module imm_extract
    import imm_gen_buffer_pkg::*;
#(
    parameter int WORD = WORD_DEFAULT
) (
    input  logic [INSTR_LEN-1:0] instr,
    output logic [WORD-1:0]      imm,
    output logic [2:0]           kind,
    output logic [5:0]           shift,
    output logic                 err
);

    logic [1:0]      hw;
    logic [63:0]     wide;
    logic [WORD-1:0] branch;
    logic            unused_bits;

    assign hw          = instr[22:21];
    assign wide        = {48'b0, instr[20:5]} << {hw, 4'b0000};
    assign unused_bits = ^instr[4:0];

    always_comb begin
        kind   = IMM_KIND_NONE;
        imm    = '0;
        shift  = '0;
        err    = 1'b0;
        branch = '0;
        casez (instr[31:21])
            OP_LSL, OP_LSR: begin
                kind = IMM_KIND_SHAMT;
                imm  = {{(WORD-6){instr[15]}}, instr[15:10]};
            end
            OP_ADDI, OP_ANDI, OP_ORRI, OP_EORI, OP_SUBI, OP_CMPI: begin
                kind = IMM_KIND_ALU12;
                imm  = {{(WORD-12){instr[21]}}, instr[21:10]};
            end
            OP_LDUR, OP_STUR, OP_LDA: begin
                kind = IMM_KIND_DT9;
                imm  = {{(WORD-9){instr[20]}}, instr[20:12]};
            end
            OP_CBZ, OP_CBNZ, OP_BCOND: begin
                kind   = IMM_KIND_COND19;
                branch = {{(WORD-19){instr[23]}}, instr[23:5]};
            end
            OP_B, OP_BL: begin
                kind   = IMM_KIND_BR26;
                branch = {{(WORD-26){instr[25]}}, instr[25:0]};
            end
            OP_MOVZ, OP_MOVK: begin
                kind  = IMM_KIND_WIDE16;
                shift = {hw, 4'b0000};
                // a 32-bit datapath cannot place the halfword above bit 31
                if (WORD == 32 && hw[1]) begin
                    err = 1'b1;
                end else begin
                    imm = wide[WORD-1:0];
                end
            end
            default: ;
        endcase
        if (kind == IMM_KIND_COND19 || kind == IMM_KIND_BR26) begin
`ifdef LEGV8_BR_SCALE_EN
            imm = {branch[WORD-3:0], 2'b00};
`else
            imm = branch;
`endif
        end
    end

endmodule

// File: rtl/imm_gen_buffer.sv
// rtl/imm_gen_buffer.sv - decode immediate generator feeding a small valid/ready FIFO toward execute
module imm_gen_buffer
    import imm_gen_buffer_pkg::*;
#(
    parameter int WORD      = WORD_DEFAULT,
    parameter int BUF_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSTR_LEN-1:0] in_instr,
    input  logic [WORD-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD-1:0]      out_imm,
    output logic [2:0]           out_kind,
    output logic [5:0]           out_shift,
    output logic                 out_err,
    output logic [WORD-1:0]      out_pc,
    output logic [INSTR_LEN-1:0] out_instr
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

    typedef struct packed {
        logic [WORD-1:0]      imm;
        logic [2:0]           kind;
        logic [5:0]           shift;
        logic                 err;
        logic [WORD-1:0]      pc;
        logic [INSTR_LEN-1:0] instr;
    } entry_t;

    entry_t          mem [BUF_DEPTH];
    entry_t          in_entry;
    entry_t          head;
    logic [WORD-1:0] x_imm;
    logic [2:0]      x_kind;
    logic [5:0]      x_shift;
    logic            x_err;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;

    imm_extract #(.WORD(WORD)) u_extract (
        .instr (in_instr),
        .imm   (x_imm),
        .kind  (x_kind),
        .shift (x_shift),
        .err   (x_err)
    );

    assign in_entry  = '{imm: x_imm, kind: x_kind, shift: x_shift, err: x_err, pc: in_pc, instr: in_instr};
    assign in_ready  = count < FULL;
    assign out_valid = count != '0;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_entry;
    end

    // storage is never cleared, so the head is masked to zero while empty
    assign head      = out_valid ? mem[rd_ptr] : '0;
    assign out_imm   = head.imm;
    assign out_kind  = head.kind;
    assign out_shift = head.shift;
    assign out_err   = head.err;
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

endmodule

// File: tb/tb_imm_gen_buffer.sv
// tb/tb_imm_gen_buffer.sv - scoreboard bench for imm_gen_buffer with a behavioural immediate model
module tb_imm_gen_buffer;

    logic        clk = 1'b0;
    logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [31:0] in_instr, out_instr;
    logic [63:0] in_pc, out_imm, out_pc;
    logic [2:0]  out_kind;
    logic [5:0]  out_shift;

    logic        flush32, in_valid32, in_ready32, out_valid32, out_ready32, out_err32;
    logic [31:0] in_instr32, out_instr32, in_pc32, out_imm32, out_pc32;
    logic [2:0]  out_kind32;
    logic [5:0]  out_shift32;

    imm_gen_buffer #(.WORD(64), .BUF_DEPTH(2)) u_dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_kind(out_kind),
        .out_shift(out_shift), .out_err(out_err), .out_pc(out_pc), .out_instr(out_instr)
    );

    imm_gen_buffer #(.WORD(32), .BUF_DEPTH(2)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .flush(flush32),
        .in_valid(in_valid32), .in_ready(in_ready32), .in_instr(in_instr32), .in_pc(in_pc32),
        .out_valid(out_valid32), .out_ready(out_ready32), .out_imm(out_imm32), .out_kind(out_kind32),
        .out_shift(out_shift32), .out_err(out_err32), .out_pc(out_pc32), .out_instr(out_instr32)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  kind;
        logic [5:0]  shift;
        logic        err;
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

`ifdef LEGV8_BR_SCALE_EN
    localparam longint BR_MUL = 4;
    localparam logic [63:0] B_EXP = 64'hFFFF_FFFF_FFFF_FFFC;
`else
    localparam longint BR_MUL = 1;
    localparam logic [63:0] B_EXP = 64'hFFFF_FFFF_FFFF_FFFF;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic exp_t model(input logic [31:0] i, input logic [63:0] pc);
        exp_t        e;
        logic [10:0] op;
        longint      v;
        int          hw;
        op = i[31:21];
        hw = int'(i[22:21]);
        v = 0;
        e.kind = 3'd0;
        e.shift = 6'd0;
        e.err = 1'b0;
        if (op ==? 11'b1101001101?) begin
            e.kind = 3'd1; v = longint'($signed(i[15:10]));
        end else if (op ==? 11'b1001000100? || op ==? 11'b1001001000? || op ==? 11'b1011001000? ||
                     op ==? 11'b1101001000? || op ==? 11'b1101000100? || op ==? 11'b1111000100?) begin
            e.kind = 3'd2; v = longint'($signed(i[21:10]));
        end else if (op == 11'b11111000010 || op == 11'b11111000000 || op == 11'b11111000110) begin
            e.kind = 3'd3; v = longint'($signed(i[20:12]));
        end else if (op ==? 11'b1011010???? || op ==? 11'b01010100???) begin
            e.kind = 3'd4; v = longint'($signed(i[23:5])) * BR_MUL;
        end else if (op ==? 11'b?00101?????) begin
            e.kind = 3'd5; v = longint'($signed(i[25:0])) * BR_MUL;
        end else if (op ==? 11'b11?100101??) begin
            e.kind = 3'd6;
            e.shift = 6'(16 * hw);
            v = longint'(i[20:5]);
            repeat (hw) v = v * 65536;
        end
        e.imm = 64'(v);
        e.pc = pc;
        e.instr = i;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [10:0] ops   [18] = '{11'b11010011011, 11'b11010011010, 11'b10010001000, 11'b10010010000,
                                    11'b10110010000, 11'b11010010000, 11'b11010001000, 11'b11110001000,
                                    11'b11111000010, 11'b11111000000, 11'b11111000110, 11'b10110100000,
                                    11'b10110101000, 11'b01010100000, 11'b00010100000, 11'b10010100000,
                                    11'b11010010100, 11'b11110010100};
        logic [10:0] masks [18] = '{11'd0, 11'd0, 11'd1, 11'd1, 11'd1, 11'd1, 11'd1, 11'd1,
                                    11'd0, 11'd0, 11'd0, 11'd7, 11'd7, 11'd7, 11'd31, 11'd31,
                                    11'd3, 11'd3};
        logic [31:0] r;
        int          k;
        r = $urandom;
        if ($urandom_range(0, 5) == 0) return r;
        k = $urandom_range(0, 17);
        return {ops[k] | (r[31:21] & masks[k]), r[20:0]};
    endfunction

    // monitor: checks handshake state and head contents against the scoreboard every cycle
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                sb.delete();
            end else begin
                chk("in_ready", in_ready, sb.size() < 2);
                chk("out_valid", out_valid, sb.size() != 0);
                if (out_valid && sb.size() != 0) begin
                    e = sb[0];
                    chk("head_imm", out_imm, e.imm);
                    chk("head_kind", out_kind, e.kind);
                    chk("head_shift", out_shift, e.shift);
                    chk("head_err", out_err, e.err);
                    chk("head_pc", out_pc, e.pc);
                    chk("head_instr", out_instr, e.instr);
                    if (out_ready) void'(sb.pop_front());
                end
                if (flush) sb.delete();
                else if (in_valid && in_ready) sb.push_back(model(in_instr, in_pc));
            end
        end
    end

    task automatic send(input logic [31:0] ins, input logic [63:0] pc);
        int   n = 0;
        logic acc;
        in_instr = ins;
        in_pc = pc;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            acc = in_ready && !flush;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 50) begin
                chk("send_timeout", 64'd0, 64'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", out_valid, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        reset_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        flush32 = 1'b0; in_valid32 = 1'b0; out_ready32 = 1'b1; in_instr32 = '0; in_pc32 = '0;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_imm", out_imm, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // 32-bit datapath: hw=2 is illegal, hw=1 is fine
        in_valid32 = 1'b1; in_instr32 = 32'hD2D7DDE3;
        @(posedge clk); #1;
        chk("w32_valid", out_valid32, 1);
        chk("w32_err", out_err32, 1);
        chk("w32_imm", out_imm32, 0);
        chk("w32_shift", out_shift32, 32);
        chk("w32_kind", out_kind32, 6);
        in_instr32 = 32'hD2B7DDE3;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        chk("w32h1_err", out_err32, 0);
        chk("w32h1_imm", out_imm32, 32'hBEEF_0000);
        chk("w32h1_shift", out_shift32, 16);

        // directed immediates, no backpressure
        out_ready = 1'b1;
        send(32'h913FFC41, 64'h1000);
        chk("addi_latency", out_valid, 1);
        chk("addi_kind", out_kind, 2);
        chk("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_shift", out_shift, 0);
        send(32'hF85F8020, 64'h1004);
        chk("ldur_kind", out_kind, 3);
        chk("ldur_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        send(32'hD2D7DDE3, 64'h1008);
        chk("movz_kind", out_kind, 6);
        chk("movz_imm", out_imm, 64'h0000_BEEF_0000_0000);
        chk("movz_shift", out_shift, 32);
        chk("movz_err", out_err, 0);
        send(32'h17FFFFFF, 64'h100C);
        chk("b_kind", out_kind, 5);
        chk("b_imm", out_imm, B_EXP);
        drain();

        // backpressure: A,B fill the buffer, C waits upstream
        out_ready = 1'b0;
        send(32'h913FFC41, 64'hA0);
        send(32'hF85F8020, 64'hB0);
        chk("bp_full", in_ready, 0);
        in_instr = 32'h17FFFFFF; in_pc = 64'hC0; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_head_stable", out_pc, 64'hA0);
        chk("bp_still_full", in_ready, 0);
        out_ready = 1'b1;
        send(32'h17FFFFFF, 64'hC0);
        chk("popush_in_ready", in_ready, 1);
        chk("popush_head", out_pc, 64'hC0);
        drain();

        // flush with one entry queued and a push presented in the same cycle
        out_ready = 1'b0;
        send(32'hD2D7DDE3, 64'hD0);
        in_instr = 32'h913FFC41; in_pc = 64'hD4; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush1_valid", out_valid, 0);
        chk("flush1_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("flush1_lost", out_valid, 0);

        // flush with two entries queued
        send(32'h913FFC41, 64'hE0);
        send(32'hF85F8020, 64'hE4);
        in_instr = 32'h17FFFFFF; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush2_valid", out_valid, 0);

        // asynchronous reset mid-stream
        send(32'h913FFC41, 64'hF0);
        send(32'hF85F8020, 64'hF4);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_imm", out_imm, 0);
        chk("arst_pc", out_pc, 0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_valid_after", out_valid, 0);

        // randomized traffic, backpressure and occasional flush
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 24) == 0;
            in_instr  = rand_instr();
            in_pc     = {$urandom, $urandom};
        end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        drain();
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
